// File: rtl/div_rr_scheduler.sv
// Round-robin front end for a single shared iterative divider: arbitrates two
// requesters, launches the divider, short-circuits x/0 and aborts hung operations.
module div_rr_scheduler #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_q,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_err,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic             div_en,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  input  logic             div_done,
  output logic             busy,
  output logic [1:0]       state_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_e           state_q;
  logic             owner_q;
  logic             last_grant_q;
  logic [7:0]       timer_q;
  logic [7:0]       timer_d;
  logic [WIDTH-1:0] div_a_q, div_b_q;
  logic [WIDTH-1:0] quo_q, rem_q;
  logic             err_q;

  logic             grant0, grant1;
  logic [WIDTH-1:0] sel_a, sel_b;

  // Contention goes to whichever side was not served last.
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant_q;
      grant1 = ~last_grant_q;
    end
  end

  assign sel_a   = grant1 ? req1_a : req0_a;
  assign sel_b   = grant1 ? req1_b : req0_b;
  assign timer_d = timer_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      timer_q      <= 8'd0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            div_a_q <= sel_a;
            div_b_q <= sel_b;
            owner_q <= grant1;
            if (sel_b == '0) begin
              quo_q   <= '1;
              rem_q   <= sel_a;
              err_q   <= 1'b1;
              state_q <= RESP;
            end else begin
              state_q <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          timer_q <= 8'd0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A result landing on the timeout cycle still wins.
          if (div_done) begin
            quo_q   <= div_q;
            rem_q   <= div_r;
            err_q   <= 1'b0;
            state_q <= RESP;
          end else begin
            timer_q <= timer_d;
            if (timer_d == TMO) begin
              quo_q   <= '0;
              rem_q   <= '0;
              err_q   <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        RESP: begin
          last_grant_q <= owner_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready = (state_q == IDLE) & grant0;
  assign req1_ready = (state_q == IDLE) & grant1;
  assign rsp0_valid = (state_q == RESP) & ~owner_q;
  assign rsp1_valid = (state_q == RESP) &  owner_q;
  assign rsp_q      = quo_q;
  assign rsp_r      = rem_q;
  assign rsp_err    = err_q;
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign div_en     = (state_q == LAUNCH);
  assign busy       = (state_q != IDLE);
  assign state_out  = state_q;

endmodule

// File: tb/tb_div_rr_scheduler.sv
// Bench for div_rr_scheduler: divider model with fixed latency, event monitor,
// and per-scenario tasks checked against an arithmetic reference.
module tb_div_rr_scheduler;
  localparam int W    = 4;
  localparam int TMO  = 8;
  localparam int DLAT = 6;
  localparam int BIG  = 1 << 30;

  typedef struct {
    int         cyc;
    bit         side;
    logic [W-1:0] a, b, q, r;
    logic       err;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, div_en, busy;
  logic [W-1:0] rsp_q, rsp_r, div_a, div_b, div_q, div_r;
  logic div_done;
  logic [1:0] state_out;

  div_rr_scheduler #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err),
    .div_a(div_a), .div_b(div_b), .div_en(div_en),
    .div_q(div_q), .div_r(div_r), .div_done(div_done),
    .busy(busy), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Divider model: done is seen by the DUT DLAT cycles after the div_en cycle.
  int cd = 0;
  logic [W-1:0] mq = '0, mr = '0;
  bit hang = 1'b0, stray = 1'b0;
  always @(negedge clk) begin
    if (div_en && !hang && div_b != 0) begin
      cd <= DLAT + 1;
      mq <= div_a / div_b;
      mr <= div_a % div_b;
    end else if (cd > 0) begin
      cd <= cd - 1;
    end
  end
  assign div_done = (cd == 1) || stray;
  assign div_q = mq;
  assign div_r = mr;

  // Monitor samples just before each rising edge.
  ev_t acc_log[$], en_log[$], rsp_log[$];
  ev_t mon_e;
  int cyc = 0, bad = 0, done_cnt = 0, acc_cnt0 = 0, acc_cnt1 = 0;
  always @(negedge clk) begin
    #4;
    cyc++;
    if (!rst) begin
      if (req0_ready && req1_ready) bad++;
      if ((req0_ready || req1_ready) && state_out != 2'd0) bad++;
      if (rsp0_valid && rsp1_valid) bad++;
      mon_e = '{cyc: cyc, side: 1'b0, a: '0, b: '0, q: '0, r: '0, err: 1'b0};
      if (req0_ready) begin
        mon_e.side = 1'b0; mon_e.a = req0_a; mon_e.b = req0_b;
        acc_log.push_back(mon_e); acc_cnt0++;
      end
      if (req1_ready) begin
        mon_e.side = 1'b1; mon_e.a = req1_a; mon_e.b = req1_b;
        acc_log.push_back(mon_e); acc_cnt1++;
      end
      if (div_en) begin
        mon_e.a = div_a; mon_e.b = div_b;
        en_log.push_back(mon_e);
      end
      if (div_done) done_cnt++;
      if (rsp0_valid || rsp1_valid) begin
        mon_e.side = rsp1_valid; mon_e.q = rsp_q; mon_e.r = rsp_r; mon_e.err = rsp_err;
        rsp_log.push_back(mon_e);
      end
    end
  end

  int n_pass = 0, n_total = 0;
  int drop0_at = BIG, drop1_at = BIG, drop_all_at = BIG;

  function automatic void ref_op(input logic [W-1:0] a, b, input bit hung,
                                 output logic [W-1:0] q, r, output logic e, output int lat);
    if (b == 0)    begin q = '1; r = a;     e = 1'b1; lat = 1; end
    else if (hung) begin q = '0; r = '0;    e = 1'b1; lat = TMO + 2; end
    else           begin q = a / b; r = a % b; e = 1'b0; lat = DLAT + 2; end
  endfunction

  task automatic step();
    @(negedge clk);
    if (acc_cnt0 >= drop0_at) req0_valid = 1'b0;
    if (acc_cnt1 >= drop1_at) req1_valid = 1'b0;
    if (acc_cnt0 + acc_cnt1 >= drop_all_at) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    #3;
  endtask

  task automatic wait_rsp(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (rsp_log.size() >= target) begin ok = 1'b1; break; end
    end
    drop0_at = BIG; drop1_at = BIG; drop_all_at = BIG;
  endtask

  task automatic test_reset();
    step();
    n_total++;
    if ({state_out, busy, div_en, rsp0_valid, rsp1_valid} !== 5'd0) begin
      $display("FAIL reset_ctrl: got %b expected 00000", {state_out, busy, div_en, rsp0_valid, rsp1_valid});
    end else n_pass++;
    n_total++;
    if ({div_a, div_b, rsp_q, rsp_r, rsp_err} !== '0) begin
      $display("FAIL reset_data: got %h expected 0", {div_a, div_b, rsp_q, rsp_r, rsp_err});
    end else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int ba, be, br; bit ok;
    logic [W-1:0] eq, er; logic ee; int lat;
    ba = acc_log.size(); be = en_log.size(); br = rsp_log.size();
    req0_a = 4'd13; req0_b = 4'd5; req0_valid = 1'b1; drop0_at = acc_cnt0 + 1;
    wait_rsp(br + 1, 40, ok);
    repeat (2) step();
    ref_op(4'd13, 4'd5, 1'b0, eq, er, ee, lat);
    n_total++;
    if (!ok || acc_log.size() != ba + 1 || en_log.size() != be + 1 || rsp_log.size() != br + 1) begin
      $display("FAIL single_counts: got acc=%0d en=%0d rsp=%0d expected 1 each",
               acc_log.size() - ba, en_log.size() - be, rsp_log.size() - br);
    end else n_pass++;
    if (ok) begin
      n_total++;
      if (en_log[be].a !== 4'd13 || en_log[be].b !== 4'd5 || en_log[be].cyc != acc_log[ba].cyc + 1) begin
        $display("FAIL single_launch: got a=%0d b=%0d dcyc=%0d expected 13 5 1",
                 en_log[be].a, en_log[be].b, en_log[be].cyc - acc_log[ba].cyc);
      end else n_pass++;
      n_total++;
      if (rsp_log[br].side !== 1'b0 || rsp_log[br].q !== eq || rsp_log[br].r !== er ||
          rsp_log[br].err !== ee || rsp_log[br].cyc - acc_log[ba].cyc != lat) begin
        $display("FAIL single_rsp: got side=%0d q=%0d r=%0d e=%0d lat=%0d expected 0 %0d %0d %0d %0d",
                 rsp_log[br].side, rsp_log[br].q, rsp_log[br].r, rsp_log[br].err,
                 rsp_log[br].cyc - acc_log[ba].cyc, eq, er, ee, lat);
      end else n_pass++;
    end
  endtask

  task automatic test_contention();
    int ba, be, br, rem0, rem1; bit ok, lg, g;
    logic [W-1:0] eq, er, ea, eb; logic ee; int lat;
    rst = 1'b1; step(); rst = 1'b0;
    ba = acc_log.size(); be = en_log.size(); br = rsp_log.size();
    req0_a = 4'd3; req0_b = 4'd2; req1_a = 4'd13; req1_b = 4'd5;
    req0_valid = 1'b1; req1_valid = 1'b1;
    drop0_at = acc_cnt0 + 2; drop1_at = acc_cnt1 + 2;
    wait_rsp(br + 4, 120, ok);
    step();
    n_total++;
    if (!ok || acc_log.size() != ba + 4 || en_log.size() != be + 4) begin
      $display("FAIL contention_counts: got acc=%0d en=%0d expected 4 4", acc_log.size() - ba, en_log.size() - be);
    end else n_pass++;
    lg = 1'b1; rem0 = 2; rem1 = 2;
    for (int k = 0; k < 4 && ok; k++) begin
      g = (rem0 > 0 && rem1 > 0) ? !lg : (rem0 > 0 ? 1'b0 : 1'b1);
      lg = g;
      if (g) rem1--; else rem0--;
      ea = g ? 4'd13 : 4'd3; eb = g ? 4'd5 : 4'd2;
      ref_op(ea, eb, 1'b0, eq, er, ee, lat);
      n_total++;
      if (acc_log[ba+k].side !== g || rsp_log[br+k].side !== g || rsp_log[br+k].q !== eq ||
          rsp_log[br+k].r !== er || rsp_log[br+k].err !== ee ||
          rsp_log[br+k].cyc - acc_log[ba+k].cyc != lat) begin
        $display("FAIL contention_op%0d: got grant=%0d rsp=%0d q=%0d r=%0d e=%0d expected %0d %0d %0d %0d %0d",
                 k, acc_log[ba+k].side, rsp_log[br+k].side, rsp_log[br+k].q, rsp_log[br+k].r,
                 rsp_log[br+k].err, g, g, eq, er, ee);
      end else n_pass++;
    end
  endtask

  task automatic test_zero_div();
    int ba, be, br; bit ok;
    ba = acc_log.size(); be = en_log.size(); br = rsp_log.size();
    req1_a = 4'd9; req1_b = 4'd0; req1_valid = 1'b1; drop1_at = acc_cnt1 + 1;
    wait_rsp(br + 1, 20, ok);
    repeat (2) step();
    n_total++;
    if (!ok || en_log.size() != be || acc_log.size() != ba + 1) begin
      $display("FAIL zero_div_noen: got en=%0d acc=%0d expected 0 1", en_log.size() - be, acc_log.size() - ba);
    end else n_pass++;
    if (ok) begin
      n_total++;
      if (rsp_log[br].side !== 1'b1 || rsp_log[br].q !== 4'd15 || rsp_log[br].r !== 4'd9 ||
          rsp_log[br].err !== 1'b1 || rsp_log[br].cyc != acc_log[ba].cyc + 1) begin
        $display("FAIL zero_div_rsp: got side=%0d q=%0d r=%0d e=%0d lat=%0d expected 1 15 9 1 1",
                 rsp_log[br].side, rsp_log[br].q, rsp_log[br].r, rsp_log[br].err,
                 rsp_log[br].cyc - acc_log[ba].cyc);
      end else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int ba, be, br; bit ok;
    logic [W-1:0] eq, er; logic ee; int lat;
    ba = acc_log.size(); be = en_log.size(); br = rsp_log.size();
    hang = 1'b1;
    req0_a = 4'd7; req0_b = 4'd3; req0_valid = 1'b1; drop0_at = acc_cnt0 + 1;
    wait_rsp(br + 1, 40, ok);
    hang = 1'b0;
    ref_op(4'd7, 4'd3, 1'b1, eq, er, ee, lat);
    n_total++;
    if (!ok || rsp_log[br].side !== 1'b0 || rsp_log[br].q !== eq || rsp_log[br].r !== er ||
        rsp_log[br].err !== ee || rsp_log[br].cyc - en_log[be].cyc != TMO + 1) begin
      $display("FAIL timeout_rsp: got ok=%0d q=%0d r=%0d e=%0d after_launch=%0d expected 1 0 0 1 %0d",
               ok, rsp_log[br].q, rsp_log[br].r, rsp_log[br].err, rsp_log[br].cyc - en_log[be].cyc, TMO + 1);
    end else n_pass++;
    step();
    ba = acc_log.size(); br = rsp_log.size();
    req1_a = 4'd6; req1_b = 4'd4; req1_valid = 1'b1; drop1_at = acc_cnt1 + 1;
    wait_rsp(br + 1, 40, ok);
    ref_op(4'd6, 4'd4, 1'b0, eq, er, ee, lat);
    n_total++;
    if (!ok || rsp_log[br].side !== 1'b1 || rsp_log[br].q !== eq || rsp_log[br].r !== er ||
        rsp_log[br].err !== ee || rsp_log[br].cyc - acc_log[ba].cyc != lat) begin
      $display("FAIL after_timeout: got ok=%0d q=%0d r=%0d e=%0d expected 1 %0d %0d %0d",
               ok, rsp_log[br].q, rsp_log[br].r, rsp_log[br].err, eq, er, ee);
    end else n_pass++;
    step();
  endtask

  task automatic test_reset_in_wait();
    int be, br, dc, n; bit ok;
    be = en_log.size(); br = rsp_log.size();
    req0_a = 4'd13; req0_b = 4'd5; req0_valid = 1'b1; drop0_at = acc_cnt0 + 1;
    n = 0;
    while (en_log.size() == be && n < 20) begin step(); n++; end
    repeat (2) step();
    drop0_at = BIG;
    n_total++;
    if (state_out !== 2'd2) begin
      $display("FAIL rst_wait_pre: got state=%0d expected 2", state_out);
    end else n_pass++;
    dc = done_cnt;
    rst = 1'b1; #1;
    n_total++;
    if ({state_out, busy, div_a, div_b, rsp_q, rsp_r, rsp_err, rsp0_valid} !== '0) begin
      $display("FAIL rst_wait_clear: got state=%0d busy=%0d a=%0d b=%0d q=%0d r=%0d e=%0d expected all 0",
               state_out, busy, div_a, div_b, rsp_q, rsp_r, rsp_err);
    end else n_pass++;
    step(); rst = 1'b0;
    repeat (8) step();
    n_total++;
    if (rsp_log.size() != br || done_cnt != dc + 1 || state_out !== 2'd0) begin
      $display("FAIL rst_wait_stray: got rsp=%0d done=%0d state=%0d expected 0 1 0",
               rsp_log.size() - br, done_cnt - dc, state_out);
    end else n_pass++;
    req0_a = 4'd3; req0_b = 4'd2; req0_valid = 1'b1; drop0_at = acc_cnt0 + 1;
    wait_rsp(br + 1, 40, ok);
    n_total++;
    if (!ok || rsp_log[br].side !== 1'b0 || rsp_log[br].q !== 4'd1 || rsp_log[br].r !== 4'd1 || rsp_log[br].err !== 1'b0) begin
      $display("FAIL rst_wait_next: got ok=%0d q=%0d r=%0d e=%0d expected 1 1 1 0",
               ok, rsp_log[br].q, rsp_log[br].r, rsp_log[br].err);
    end else n_pass++;
    step();
  endtask

  task automatic test_stray_done();
    int br;
    logic [W-1:0] hq, hr; logic he;
    br = rsp_log.size(); hq = rsp_log[br-1].q; hr = rsp_log[br-1].r; he = rsp_log[br-1].err;
    stray = 1'b1;
    step();
    stray = 1'b0;
    step();
    n_total++;
    if (busy !== 1'b0 || state_out !== 2'd0 || rsp_log.size() != br ||
        rsp_q !== hq || rsp_r !== hr || rsp_err !== he) begin
      $display("FAIL stray_done: got busy=%0d state=%0d rsp=%0d q=%0d r=%0d e=%0d expected 0 0 0 %0d %0d %0d",
               busy, state_out, rsp_log.size() - br, rsp_q, rsp_r, rsp_err, hq, hr, he);
    end else n_pass++;
  endtask

  task automatic test_random();
    int ba, br; bit ok, lg, v0, v1, g;
    logic [W-1:0] a0, b0, a1, b1, eq, er; logic ee; int lat;
    rst = 1'b1; step(); rst = 1'b0;
    lg = 1'b1;
    for (int k = 0; k < 24; k++) begin
      v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      a0 = 4'($urandom); a1 = 4'($urandom);
      b0 = (k % 7 == 3) ? 4'd0 : 4'($urandom);
      b1 = (k % 5 == 2) ? 4'd0 : 4'($urandom);
      ba = acc_log.size(); br = rsp_log.size();
      req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
      req0_valid = v0; req1_valid = v1;
      drop_all_at = acc_cnt0 + acc_cnt1 + 1;
      wait_rsp(br + 1, 40, ok);
      g = (v0 && v1) ? !lg : v1;
      lg = g;
      ref_op(g ? a1 : a0, g ? b1 : b0, 1'b0, eq, er, ee, lat);
      n_total++;
      if (!ok || acc_log[ba].side !== g || rsp_log[br].side !== g || rsp_log[br].q !== eq ||
          rsp_log[br].r !== er || rsp_log[br].err !== ee || rsp_log[br].cyc - acc_log[ba].cyc != lat) begin
        $display("FAIL random_%0d: got ok=%0d grant=%0d q=%0d r=%0d e=%0d lat=%0d expected 1 %0d %0d %0d %0d %0d",
                 k, ok, acc_log[ba].side, rsp_log[br].q, rsp_log[br].r, rsp_log[br].err,
                 rsp_log[br].cyc - acc_log[ba].cyc, g, eq, er, ee, lat);
      end else n_pass++;
    end
    step();
    n_total++;
    if (bad != 0) begin
      $display("FAIL handshake_rules: got %0d violations expected 0", bad);
    end else n_pass++;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_zero_div();
    test_timeout();
    test_reset_in_wait();
    test_stray_done();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
